mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Sequencer that shares the single RAM port among all instruction and data caches of the multicore system. It sits between the per-core icache/dcache miss ports and the RAM, picks one requester at a time, holds the grant until the RAM reports completion, and returns the result by dropping only that requester's wait. Data requests have priority over instruction fetches. Within each class, grant rotates between cores.

## Interface
- CPUS, 2, number of cores; each core has one icache port and one dcache port.
- AW, 32, address width.
- DW, 32, data word width.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- iREN  in  CPUS  instruction read request per core.
- iaddr  in  CPUS*AW  instruction address per core; core k in bits [k*AW +: AW].
- iwait  out  CPUS  per-core instruction wait; 0 means completion this cycle.
- iload  out  CPUS*DW  instruction data per core.
- dREN  in  CPUS  data read request per core.
- dWEN  in  CPUS  data write request per core.
- daddr  in  CPUS*AW  data address per core.
- dstore  in  CPUS*DW  data to write per core.
- dwait  out  CPUS  per-core data wait.
- dload  out  CPUS*DW  data read result per core.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  AW  RAM address.
- ramstore  out  DW  RAM write data.
- ramload  in  DW  RAM read data.
- ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.

## Operation
- FSM states:
  - ARB: RAM enables low; all waits high.
    - If any request is pending, register the winner (class, core index, read/write) and go to XFER.
    - If no request is pending, stay in ARB.
  - XFER: drive ramaddr, ramstore, ramREN/ramWEN from the registered winner.
    - On ramstate==ACCESS: winner's wait=0 this cycle, ramload routed to that winner's load bus, advance that class's pointer, go to ARB.
    - BUSY, FREE and ERROR: keep all waits high and stay in XFER. ERROR is retried, never reported as completion.
- Winner selection:
  - Any dREN or dWEN beats any iREN.
  - Within a class, the round-robin pointer selects the first requesting core at or after the pointer, wrapping modulo CPUS.
  - After a grant, the pointer moves to the winner index + 1, with wrap.
  - Data and instruction classes each have their own pointer.
- If dREN and dWEN are both high on one core, treat it as a write; ramREN stays 0.
- Requester withdrawal: if the winner's enable drops while in XFER, deassert RAM enables the same cycle, go to ARB, and leave the pointer unchanged.
- Loads: iload/dload for every core is a combinational copy of ramload. Each value is valid only when that core's wait is 0.
- Only the winner's wait ever goes low; non-granted waits are high in every state.

## Timing
- Reset values:
  - iwait and dwait all 1.
  - ramREN, ramWEN 0; ramaddr, ramstore 0.
  - State ARB; both pointers 0.
- A request present at edge N is granted at edge N+1. RAM enables are high from cycle N+1 onward.
- Minimum latency from request to wait low is 2 cycles (RAM returns ACCESS in its first cycle).
- One ARB cycle separates back-to-back transfers. The next grant is therefore evaluated at least 1 cycle after the previous completion, so a requester that drops its enable on seeing wait=0 is not re-granted.
- Address and store data are sampled live from the winner during XFER; requesters must hold them stable until their wait is 0.
- Reset mid-XFER: RAM enables drop immediately (asynchronous) and the transfer is abandoned.

## Configuration
- MEM_ARB_RR_EN defined: round-robin within each class, as described above.
- MEM_ARB_RR_EN undefined: fixed priority within each class, lowest core index wins. Pointers are not implemented and the outputs ignore them.
- Data-over-instruction priority is identical in both builds.

## Test plan
- Reset, no requests: all waits 1, ramREN=ramWEN=0 for 10 cycles.
- Core0 iREN, iaddr=0x40, RAM gives 2 BUSY then ACCESS with ramload=0xDEADBEEF:
  - ramaddr=0x40 and ramREN=1 from cycle 1.
  - iwait[0]=0 exactly once, on the ACCESS cycle, with iload=0xDEADBEEF.
- Core0 iREN and core1 dWEN (daddr=0x80, dstore=0x12345678) in the same cycle:
  - Write granted first: ramWEN=1, ramstore=0x12345678.
  - Instruction read follows after one ARB cycle.
- Both cores hold dREN continuously, RAM always ACCESS:
  - With MEM_ARB_RR_EN, grants alternate core0, core1, core0, and so on.
  - Without it, core0 wins every grant.
- Winner drops dREN during BUSY: ramREN=0 that cycle, no wait pulse, and the next grant goes to the same core if it re-requests.
- RAM returns ERROR for 3 cycles, then ACCESS: wait stays 1 through ERROR, then pulses 0 once with the ACCESS data.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shares the single RAM port among all per-core icache/dcache miss ports; data beats instruction.
// MEM_ARB_RR_EN: round-robin within each class; undefined gives fixed lowest-index priority.
//
// state | meaning
// ARB   | RAM idle, all waits high, choose next winner
// XFER  | drive RAM from registered winner until ACCESS or withdrawal
module mem_arbiter #(
   parameter int CPUS = 2,
   parameter int AW   = 32,
   parameter int DW   = 32
) (
   input  logic               CLK,
   input  logic               nRST,
   input  logic [CPUS-1:0]    iREN,
   input  logic [CPUS*AW-1:0] iaddr,
   output logic [CPUS-1:0]    iwait,
   output logic [CPUS*DW-1:0] iload,
   input  logic [CPUS-1:0]    dREN,
   input  logic [CPUS-1:0]    dWEN,
   input  logic [CPUS*AW-1:0] daddr,
   input  logic [CPUS*DW-1:0] dstore,
   output logic [CPUS-1:0]    dwait,
   output logic [CPUS*DW-1:0] dload,
   output logic               ramREN,
   output logic               ramWEN,
   output logic [AW-1:0]      ramaddr,
   output logic [DW-1:0]      ramstore,
   input  logic [DW-1:0]      ramload,
   input  logic [1:0]         ramstate
);
   localparam int IW = (CPUS > 1) ? $clog2(CPUS) : 1;
   localparam logic [1:0] RAM_ACCESS = 2'd2;

   typedef enum logic {ARB, XFER} state_t;

   state_t          state_q, state_d;
   logic            cls_q, cls_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic            wr_q, wr_d;
   logic [CPUS-1:0] dreq;
   logic            active;

   function automatic logic [IW-1:0] pick(input logic [CPUS-1:0] req, input logic [IW-1:0] ptr);
      logic [IW-1:0] sel;
      logic          found;
      int            k;
      sel   = '0;
      found = 1'b0;
      for (int off = 0; off < CPUS; off++) begin
         k = (int'(ptr) + off) % CPUS;
         if (!found && req[k]) begin
            sel   = IW'(k);
            found = 1'b1;
         end
      end
      return sel;
   endfunction

`ifdef MEM_ARB_RR_EN
   logic [IW-1:0] ptr_d_q, ptr_d_d, ptr_i_q, ptr_i_d;

   function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
      return (int'(idx) == CPUS - 1) ? '0 : IW'(int'(idx) + 1);
   endfunction

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         ptr_d_q <= '0;
         ptr_i_q <= '0;
      end else begin
         ptr_d_q <= ptr_d_d;
         ptr_i_q <= ptr_i_d;
      end
   end
`endif

   assign dreq  = dREN | dWEN;
   assign iload = {CPUS{ramload}};
   assign dload = {CPUS{ramload}};
   // A winner that drops its enable mid-transfer abandons the grant.
   assign active = cls_q ? dreq[idx_q] : iREN[idx_q];

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= ARB;
         cls_q   <= 1'b0;
         idx_q   <= '0;
         wr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cls_q   <= cls_d;
         idx_q   <= idx_d;
         wr_q    <= wr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cls_d    = cls_q;
      idx_d    = idx_q;
      wr_d     = wr_q;
      iwait    = '1;
      dwait    = '1;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
`ifdef MEM_ARB_RR_EN
      ptr_d_d  = ptr_d_q;
      ptr_i_d  = ptr_i_q;
`endif
      case (state_q)
         ARB: begin
            if (|dreq) begin
               cls_d   = 1'b1;
`ifdef MEM_ARB_RR_EN
               idx_d   = pick(dreq, ptr_d_q);
`else
               idx_d   = pick(dreq, '0);
`endif
               wr_d    = dWEN[idx_d];
               state_d = XFER;
            end else if (|iREN) begin
               cls_d   = 1'b0;
`ifdef MEM_ARB_RR_EN
               idx_d   = pick(iREN, ptr_i_q);
`else
               idx_d   = pick(iREN, '0);
`endif
               wr_d    = 1'b0;
               state_d = XFER;
            end
         end
         XFER: begin
            ramaddr  = cls_q ? daddr[idx_q*AW +: AW] : iaddr[idx_q*AW +: AW];
            ramstore = cls_q ? dstore[idx_q*DW +: DW] : '0;
            if (!active) begin
               state_d = ARB;
            end else begin
               ramREN = ~wr_q;
               ramWEN = wr_q;
               // BUSY, FREE and ERROR all keep waiting; ERROR is simply retried.
               if (ramstate == RAM_ACCESS) begin
                  state_d = ARB;
                  if (cls_q) begin
                     dwait[idx_q] = 1'b0;
`ifdef MEM_ARB_RR_EN
                     ptr_d_d = next_idx(idx_q);
`endif
                  end else begin
                     iwait[idx_q] = 1'b0;
`ifdef MEM_ARB_RR_EN
                     ptr_i_d = next_idx(idx_q);
`endif
                  end
               end
            end
         end
         default: state_d = ARB;
      endcase
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, directed corner sequences, random vs model.
module tb_mem_arbiter;
   localparam int CPUS = 2;
   localparam int AW   = 32;
   localparam int DW   = 32;

   logic               CLK = 1'b0;
   logic               nRST;
   logic [CPUS-1:0]    iREN, dREN, dWEN, iwait, dwait;
   logic [CPUS*AW-1:0] iaddr, daddr;
   logic [CPUS*DW-1:0] dstore, iload, dload;
   logic               ramREN, ramWEN;
   logic [AW-1:0]      ramaddr;
   logic [DW-1:0]      ramstore, ramload;
   logic [1:0]         ramstate;

   int checks = 0;
   int errors = 0;

   mem_arbiter #(.CPUS(CPUS), .AW(AW), .DW(DW)) dut (
      .CLK(CLK), .nRST(nRST),
      .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dwait(dwait), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   int m_busy, m_cls, m_idx, m_wr, m_pd, m_pi;

   function automatic int pick_m(input logic [CPUS-1:0] req, input int ptr);
      for (int off = 0; off < CPUS; off++)
         if (req[(ptr + off) % CPUS]) return (ptr + off) % CPUS;
      return 0;
   endfunction

   task automatic model_reset();
      m_busy = 0; m_cls = 0; m_idx = 0; m_wr = 0; m_pd = 0; m_pi = 0;
   endtask

   task automatic model_cycle(input int cyc);
      logic [CPUS-1:0] dreq, e_iw, e_dw;
      logic            e_ren, e_wen, act;
      logic [AW-1:0]   e_addr;
      logic [DW-1:0]   e_store;
      int              ptr;
      dreq = dREN | dWEN;
      e_iw = '1; e_dw = '1; e_ren = 0; e_wen = 0; e_addr = '0; e_store = '0;
      if (m_busy != 0) begin
         act     = (m_cls != 0) ? dreq[m_idx] : iREN[m_idx];
         e_addr  = (m_cls != 0) ? daddr[m_idx*AW +: AW] : iaddr[m_idx*AW +: AW];
         e_store = (m_cls != 0) ? dstore[m_idx*DW +: DW] : '0;
         m_busy  = 0;
         if (act) begin
            e_ren = (m_wr == 0);
            e_wen = (m_wr != 0);
            if (ramstate == 2'd2) begin
`ifdef MEM_ARB_RR_EN
               if (m_cls != 0) m_pd = (m_idx + 1) % CPUS;
               else            m_pi = (m_idx + 1) % CPUS;
`endif
               if (m_cls != 0) e_dw[m_idx] = 1'b0;
               else            e_iw[m_idx] = 1'b0;
            end else begin
               m_busy = 1;
            end
         end
      end else if (dreq != 0) begin
`ifdef MEM_ARB_RR_EN
         ptr = m_pd;
`else
         ptr = 0;
`endif
         m_cls = 1; m_idx = pick_m(dreq, ptr); m_wr = dWEN[m_idx]; m_busy = 1;
      end else if (iREN != 0) begin
`ifdef MEM_ARB_RR_EN
         ptr = m_pi;
`else
         ptr = 0;
`endif
         m_cls = 0; m_idx = pick_m(iREN, ptr); m_wr = 0; m_busy = 1;
      end
      chk($sformatf("rnd%0d ramREN", cyc), ramREN, e_ren);
      chk($sformatf("rnd%0d ramWEN", cyc), ramWEN, e_wen);
      chk($sformatf("rnd%0d ramaddr", cyc), ramaddr, e_addr);
      chk($sformatf("rnd%0d ramstore", cyc), ramstore, e_store);
      chk($sformatf("rnd%0d iwait", cyc), iwait, e_iw);
      chk($sformatf("rnd%0d dwait", cyc), dwait, e_dw);
      chk($sformatf("rnd%0d loads", cyc), {iload, dload}, {CPUS*2{ramload}});
   endtask

   task automatic do_reset();
      nRST = 1'b0;
      iREN = '0; dREN = '0; dWEN = '0;
      iaddr = '0; daddr = '0; dstore = '0;
      ramstate = 2'd0; ramload = '0;
      repeat (2) @(posedge CLK);
      #1;
      chk("rst iwait", iwait, 2'b11);
      chk("rst dwait", dwait, 2'b11);
      chk("rst ram", {ramREN, ramWEN, ramaddr, ramstore}, '0);
      nRST = 1'b1;
      model_reset();
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   typedef struct {
      logic [1:0]  iren, dren, dwen, rs;
      logic [1:0]  e_iw, e_dw;
      logic        e_ren, e_wen;
      logic [31:0] e_addr, e_store;
   } vec_t;
   vec_t tbl[17];

   int        done_q[$];
   int        pulses;
   logic [1:0] rs_seq[6];

   initial begin
      tbl[0]  = '{2'b00, 2'b00, 2'b00, 2'd0, 2'b11, 2'b11, 1'b0, 1'b0, 32'h0,   32'h0};
      tbl[1]  = '{2'b01, 2'b00, 2'b00, 2'd1, 2'b11, 2'b11, 1'b0, 1'b0, 32'h0,   32'h0};
      tbl[2]  = '{2'b01, 2'b00, 2'b00, 2'd1, 2'b11, 2'b11, 1'b1, 1'b0, 32'h100, 32'h0};
      tbl[3]  = '{2'b01, 2'b00, 2'b00, 2'd3, 2'b11, 2'b11, 1'b1, 1'b0, 32'h100, 32'h0};
      tbl[4]  = '{2'b01, 2'b00, 2'b00, 2'd2, 2'b10, 2'b11, 1'b1, 1'b0, 32'h100, 32'h0};
      tbl[5]  = '{2'b00, 2'b00, 2'b00, 2'd0, 2'b11, 2'b11, 1'b0, 1'b0, 32'h0,   32'h0};
      tbl[6]  = '{2'b00, 2'b00, 2'b10, 2'd0, 2'b11, 2'b11, 1'b0, 1'b0, 32'h0,   32'h0};
      tbl[7]  = '{2'b00, 2'b00, 2'b10, 2'd1, 2'b11, 2'b11, 1'b0, 1'b1, 32'h204, 32'hA1};
      tbl[8]  = '{2'b00, 2'b00, 2'b10, 2'd2, 2'b11, 2'b01, 1'b0, 1'b1, 32'h204, 32'hA1};
      tbl[9]  = '{2'b00, 2'b10, 2'b00, 2'd0, 2'b11, 2'b11, 1'b0, 1'b0, 32'h0,   32'h0};
      tbl[10] = '{2'b00, 2'b00, 2'b00, 2'd1, 2'b11, 2'b11, 1'b0, 1'b0, 32'h204, 32'hA1};
      tbl[11] = '{2'b00, 2'b10, 2'b00, 2'd0, 2'b11, 2'b11, 1'b0, 1'b0, 32'h0,   32'h0};
      tbl[12] = '{2'b00, 2'b10, 2'b00, 2'd2, 2'b11, 2'b01, 1'b1, 1'b0, 32'h204, 32'hA1};
      tbl[13] = '{2'b01, 2'b11, 2'b00, 2'd0, 2'b11, 2'b11, 1'b0, 1'b0, 32'h0,   32'h0};
      tbl[14] = '{2'b01, 2'b11, 2'b00, 2'd2, 2'b11, 2'b10, 1'b1, 1'b0, 32'h200, 32'hA0};
      tbl[15] = '{2'b01, 2'b00, 2'b00, 2'd2, 2'b11, 2'b11, 1'b0, 1'b0, 32'h0,   32'h0};
      tbl[16] = '{2'b01, 2'b00, 2'b00, 2'd2, 2'b10, 2'b11, 1'b1, 1'b0, 32'h100, 32'h0};

      // reset, idle for 10 cycles
      do_reset();
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         chk($sformatf("idle%0d waits", i), {iwait, dwait}, 4'b1111);
         chk($sformatf("idle%0d en", i), {ramREN, ramWEN}, 2'b00);
         step();
      end

      // vector table
      do_reset();
      iaddr = {32'h104, 32'h100}; daddr = {32'h204, 32'h200}; dstore = {32'hA1, 32'hA0};
      for (int i = 0; i < 17; i++) begin
         iREN = tbl[i].iren; dREN = tbl[i].dren; dWEN = tbl[i].dwen; ramstate = tbl[i].rs;
         @(negedge CLK);
         chk($sformatf("tbl%0d iwait", i), iwait, tbl[i].e_iw);
         chk($sformatf("tbl%0d dwait", i), dwait, tbl[i].e_dw);
         chk($sformatf("tbl%0d en", i), {ramREN, ramWEN}, {tbl[i].e_ren, tbl[i].e_wen});
         chk($sformatf("tbl%0d addr", i), ramaddr, tbl[i].e_addr);
         chk($sformatf("tbl%0d store", i), ramstore, tbl[i].e_store);
         step();
      end

      // instruction read with BUSY, ERROR retries, then ACCESS
      do_reset();
      rs_seq[0] = 2'd1; rs_seq[1] = 2'd1; rs_seq[2] = 2'd3;
      rs_seq[3] = 2'd3; rs_seq[4] = 2'd3; rs_seq[5] = 2'd2;
      iREN = 2'b01; iaddr = {32'h0, 32'h40}; ramload = 32'hDEADBEEF;
      @(negedge CLK);
      chk("rd arb en", ramREN, 1'b0);
      step();
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         ramstate = rs_seq[i];
         @(negedge CLK);
         chk($sformatf("rd%0d ren", i), ramREN, 1'b1);
         chk($sformatf("rd%0d addr", i), ramaddr, 32'h40);
         chk($sformatf("rd%0d iwait", i), iwait, (i == 5) ? 2'b10 : 2'b11);
         if (iwait[0] == 1'b0) begin
            pulses++;
            chk("rd iload", iload[31:0], 32'hDEADBEEF);
         end
         step();
      end
      iREN = 2'b00; ramstate = 2'd0;
      @(negedge CLK);
      chk("rd after iwait", iwait, 2'b11);
      chk("rd pulses", pulses, 1);
      step();

      // both cores hold dREN, RAM always ACCESS
      do_reset();
      dREN = 2'b11; ramstate = 2'd2;
      done_q.delete();
      for (int i = 0; i < 12; i++) begin
         @(negedge CLK);
         if (dwait == 2'b10) done_q.push_back(0);
         else if (dwait == 2'b01) done_q.push_back(1);
         else if (dwait != 2'b11) done_q.push_back(9);
         step();
      end
      chk("alt count", done_q.size(), 6);
      for (int i = 0; i < done_q.size(); i++) begin
`ifdef MEM_ARB_RR_EN
         chk($sformatf("alt grant%0d", i), done_q[i], i % 2);
`else
         chk($sformatf("alt grant%0d", i), done_q[i], 0);
`endif
      end

      // reset asserted mid-transfer drops enables immediately
      do_reset();
      dWEN = 2'b01; daddr = {32'h0, 32'h300}; ramstate = 2'd1;
      step();
      @(negedge CLK);
      chk("midrst wen before", ramWEN, 1'b1);
      #2 nRST = 1'b0;
      #1;
      chk("midrst wen", ramWEN, 1'b0);
      chk("midrst addr", ramaddr, 32'h0);
      chk("midrst dwait", dwait, 2'b11);

      // randomized against the model
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         iREN     = 2'($urandom_range(0, 3) & $urandom_range(0, 3));
         dREN     = 2'($urandom_range(0, 3) & $urandom_range(0, 3));
         dWEN     = 2'($urandom_range(0, 3) & $urandom_range(0, 3) & $urandom_range(0, 3));
         ramstate = 2'($urandom_range(0, 3));
         iaddr    = {$urandom, $urandom};
         daddr    = {$urandom, $urandom};
         dstore   = {$urandom, $urandom};
         ramload  = $urandom;
         @(negedge CLK);
         model_cycle(c);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
